// File: rtl/nth_bit_set_from_lsb_seq.sv
// Finds the n-th set bit (LSB first) of a WIDTH-bit vector, CHUNK bits per cycle.
// Result held in DONE until ready_i; a new request is taken only in IDLE.
module nth_bit_set_from_lsb_seq #(
   parameter int WIDTH = 12,
   parameter int CHUNK = 4,
   localparam int NW = $clog2(WIDTH + 1),
   localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] vec_i,
   input  logic [NW-1:0]    n_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] nth_bit_o,
   output logic [PW-1:0]    pos_o,
   output logic             found_o
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);
   localparam logic [NW-1:0] N_MAX  = NW'(WIDTH);

   generate
      if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("nth_bit_set_from_lsb_seq: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [NW-1:0]    n_q, n_d;
   logic [WIDTH-1:0] nth_bit_q, nth_bit_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic             found_q, found_d;

   logic             hit;
   logic [PW-1:0]    hit_pos;
   logic [NW-1:0]    rank;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         k_q       <= '0;
         cnt_q     <= '0;
         vec_q     <= '0;
         n_q       <= '0;
         nth_bit_q <= '0;
         pos_q     <= '0;
         found_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         vec_q     <= vec_d;
         n_q       <= n_d;
         nth_bit_q <= nth_bit_d;
         pos_q     <= pos_d;
         found_q   <= found_d;
      end
   end

   // Rank stops advancing after the hit, so it never exceeds n and fits in NW bits;
   // on a miss it is exactly cnt plus the chunk popcount.
   always_comb begin
      hit     = 1'b0;
      hit_pos = '0;
      rank    = cnt_q;
      for (int b = 0; b < WIDTH; b++) begin
         if ((b / CHUNK) == int'(k_q) && vec_q[b] && !hit) begin
            rank = rank + NW'(1);
            if (rank == n_q) begin
               hit     = 1'b1;
               hit_pos = PW'(b);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      n_d     = n_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               vec_d   = vec_i;
               n_d     = n_i;
               k_d     = '0;
               cnt_d   = '0;
               state_d = (n_i == '0 || n_i > N_MAX) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (hit || k_q == K_LAST) begin
               state_d = DONE;
            end else begin
               k_d   = k_q + KW'(1);
               cnt_d = rank;
            end
         end
         DONE: begin
            if (ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      nth_bit_d = nth_bit_q;
      pos_d     = pos_q;
      found_d   = found_q;
      if (state_q == IDLE && valid_i) begin
         nth_bit_d = '0;
         pos_d     = '0;
         found_d   = 1'b0;
      end else if (state_q == SCAN && hit) begin
         nth_bit_d = WIDTH'(1) << hit_pos;
         pos_d     = hit_pos;
         found_d   = 1'b1;
      end else if (state_q == SCAN && k_q == K_LAST) begin
         nth_bit_d = '0;
         pos_d     = '0;
         found_d   = 1'b0;
      end
   end

   assign ready_o   = (state_q == IDLE);
   assign valid_o   = (state_q == DONE);
   assign nth_bit_o = nth_bit_q;
   assign pos_o     = pos_q;
   assign found_o   = found_q;

endmodule

// File: tb/tb_nth_bit_set_from_lsb_seq.sv
module tb_nth_bit_set_from_lsb_seq;
   localparam int W   = 12;
   localparam int C   = 4;
   localparam int NCH = W / C;
   localparam int NW  = 4;
   localparam int PW  = 4;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          valid_i;
   logic          ready_o;
   logic [W-1:0]  vec_i;
   logic [NW-1:0] n_i;
   logic          valid_o;
   logic          ready_i;
   logic [W-1:0]  nth_bit_o;
   logic [PW-1:0] pos_o;
   logic          found_o;

   int checks = 0;
   int errors = 0;

   nth_bit_set_from_lsb_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
      .vec_i(vec_i), .n_i(n_i), .valid_o(valid_o), .ready_i(ready_i),
      .nth_bit_o(nth_bit_o), .pos_o(pos_o), .found_o(found_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: walk bits LSB first counting ones; -1 when there is no n-th one.
   function automatic int ref_pos(input logic [W-1:0] v, input int n);
      int cnt = 0;
      for (int b = 0; b < W; b++) begin
         if (v[b]) begin
            cnt++;
            if (cnt == n) return b;
         end
      end
      return -1;
   endfunction

   function automatic int ref_lat(input int n, input int p);
      if (n == 0 || n > W) return 1;
      if (p < 0) return 1 + NCH;
      return 2 + p / C;
   endfunction

   task automatic chk_result(input string tag, input int p);
      logic [W-1:0] mask;
      mask = '0;
      if (p >= 0) mask[p] = 1'b1;
      chk({tag, "_valid"}, valid_o, 1);
      chk({tag, "_ready"}, ready_o, 0);
      chk({tag, "_mask"}, nth_bit_o, mask);
      chk({tag, "_pos"}, pos_o, (p < 0) ? 0 : p);
      chk({tag, "_found"}, found_o, (p >= 0) ? 1 : 0);
   endtask

   task automatic req(input string tag, input logic [W-1:0] v, input int n,
                      input int bp, input bit pulse);
      int p, lat, cyc;
      p   = ref_pos(v, n);
      lat = ref_lat(n, p);
      @(negedge clk_i);
      chk({tag, "_idle_ready"}, ready_o, 1);
      valid_i = 1'b1;
      vec_i   = v;
      n_i     = n[NW-1:0];
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      cyc = 1;
      while (!valid_o && cyc < 20) begin
         vec_i = W'($urandom);
         n_i   = NW'($urandom);
         @(negedge clk_i);
         cyc++;
      end
      chk({tag, "_latency"}, cyc, lat);
      for (int i = 0; i < bp; i++) begin
         chk_result({tag, "_bp"}, p);
         valid_i = pulse && (i == 1);
         @(negedge clk_i);
      end
      valid_i = 1'b0;
      chk_result(tag, p);
      ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      ready_i = 1'b0;
      chk({tag, "_after_valid"}, valid_o, 0);
      chk({tag, "_after_ready"}, ready_o, 1);
   endtask

   initial begin
      reset_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      vec_i   = '0;
      n_i     = '0;
      #1;
      chk("rst_ready", ready_o, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_mask", nth_bit_o, 0);
      chk("rst_pos", pos_o, 0);
      chk("rst_found", found_o, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;

      req("t1", 12'b001001000000, 2, 0, 1'b0);
      req("t2a", 12'b000000100000, 2, 0, 1'b0);
      req("t2b", 12'b000000000000, 1, 0, 1'b0);
      req("t3a", 12'b111100001111, 2, 0, 1'b0);
      req("t3b", 12'b111100001111, 5, 0, 1'b0);
      req("t4a", 12'b111111111111, 0, 0, 1'b0);
      req("t4b", 12'b111111111111, 13, 0, 1'b0);
      req("t4c", 12'b111111111111, 12, 0, 1'b0);
      req("t5", 12'b001001000000, 2, 3, 1'b1);

      // Abort a scan with reset in cycle T+2.
      @(negedge clk_i);
      valid_i = 1'b1;
      vec_i   = 12'b001001000000;
      n_i     = 4'd2;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      chk("t6_ready", ready_o, 1);
      chk("t6_valid", valid_o, 0);
      chk("t6_mask", nth_bit_o, 0);
      chk("t6_pos", pos_o, 0);
      chk("t6_found", found_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      req("t6_next", 12'b001001000000, 2, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         req("rnd", W'($urandom), $urandom_range(0, 13), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
